// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit for the 5-stage RV32I pipeline: per-operand M/W forwarding plus load-use stall FSM.
// Latency: forward selects, SrcE and stall/flush outputs are combinational; RsE is registered from Decode.
// Backpressure: a load-use hazard holds F/D and bubbles E for LOAD_LAT cycles; a taken branch overrides it.
// Optional: define HAZARD_PERF_CNT_EN to add StallCnt/FwdCnt performance counters.
module hazard_forward_unit #(
  parameter int WIDTH    = 32,
  parameter int NPORTS   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS*5-1:0]     RsD,
  input  logic [NPORTS-1:0]       RsUsedD,
  input  logic [4:0]              RdE,
  input  logic [4:0]              RdM,
  input  logic [4:0]              RdW,
  input  logic                    RegWriteE,
  input  logic                    RegWriteM,
  input  logic                    RegWriteW,
  input  logic                    MemReadE,
  input  logic                    MemReadM,
  input  logic                    PCSrcE,
  input  logic [NPORTS*WIDTH-1:0] RDE,
  input  logic [WIDTH-1:0]        ALUResultM,
  input  logic [WIDTH-1:0]        ResultW,
  output logic [NPORTS*WIDTH-1:0] SrcE,
  output logic [NPORTS*2-1:0]     ForwardE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]             StallCnt,
  output logic [31:0]             FwdCnt,
`endif
  output logic                    StallF,
  output logic                    StallD,
  output logic                    FlushD,
  output logic                    FlushE
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  logic [NPORTS*5-1:0] rs_e_q;
  logic [NPORTS-1:0]   rs_used_e_q;
  logic [NPORTS*2-1:0] fwd_sel;
  logic                loaduse;
  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                stall, flush_d, flush_e;

  // A load always writes its destination, so RegWriteE adds nothing to load-use detection.
  logic unused_regwrite_e;
  assign unused_regwrite_e = RegWriteE;

  // Source indices follow the D/E register: bubble on FlushE, hold on StallD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_e_q      <= '0;
      rs_used_e_q <= '0;
    end else if (FlushE) begin
      rs_e_q      <= '0;
      rs_used_e_q <= '0;
    end else if (!StallD) begin
      rs_e_q      <= RsD;
      rs_used_e_q <= RsUsedD;
    end
  end

  // Per-port forward select: M beats W, x0 and loads in M never forward.
  always_comb begin
    fwd_sel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (rs_used_e_q[p] && (rs_e_q[5*p +: 5] != 5'd0)) begin
        if (RegWriteM && !MemReadM && (RdM == rs_e_q[5*p +: 5]))
          fwd_sel[2*p +: 2] = 2'b10;
        else if (RegWriteW && (RdW == rs_e_q[5*p +: 5]))
          fwd_sel[2*p +: 2] = 2'b01;
      end
    end
  end

  assign ForwardE = fwd_sel;

  // Operand mux; the unused code 11 falls back to the register-file value.
  always_comb begin
    SrcE = '0;
    for (int p = 0; p < NPORTS; p++) begin
      case (fwd_sel[2*p +: 2])
        2'b10:   SrcE[WIDTH*p +: WIDTH] = ALUResultM;
        2'b01:   SrcE[WIDTH*p +: WIDTH] = ResultW;
        default: SrcE[WIDTH*p +: WIDTH] = RDE[WIDTH*p +: WIDTH];
      endcase
    end
  end

  // Load in E whose destination (non-x0) is read by the instruction in Decode.
  always_comb begin
    loaduse = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (RsUsedD[p] && (RsD[5*p +: 5] == RdE))
        loaduse = 1'b1;
    end
    loaduse = loaduse && MemReadE && (RdE != 5'd0);
  end

  // Stall FSM state and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/flush controls; a taken branch always wins over a stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (loaduse) begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          stall   = 1'b1;
          flush_e = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1)
            state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Controls read as idle while reset is held, even if hazard inputs are still live.
  assign StallF = stall & ~rst;
  assign StallD = stall & ~rst;
  assign FlushD = flush_d & ~rst;
  assign FlushE = flush_e & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] fwd_inc;

  // Number of ports taking a forwarded value this cycle.
  always_comb begin
    fwd_inc = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (fwd_sel[2*p +: 2] != 2'b00)
        fwd_inc = fwd_inc + 32'd1;
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FwdCnt   <= '0;
    end else begin
      if (StallD)
        StallCnt <= StallCnt + 32'd1;
      FwdCnt <= FwdCnt + fwd_inc;
    end
  end
`endif

endmodule
